// File: rtl/flash_loader.sv
// -----------------------------------------------------------------------------
// flash_loader
//
// Boot-time copy engine placed downstream of the SPI flash controller. A start
// pulse issues one addressed read at FLASH_BASE, then LENGTH sequential bytes
// are streamed from the controller and written into RAM starting at RAM_BASE
// (address wraps modulo 2^RAM_ADDR_W). Completion is flagged by a sticky done.
//
// Parameters:
//   FLASH_BASE  first flash byte address (driven constantly on flash_addr)
//   RAM_BASE    first RAM write address
//   LENGTH      bytes to copy, 1 .. 2^RAM_ADDR_W
//   RAM_ADDR_W  RAM address width
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   start                 one-cycle pulse, begins a copy when idle
//   busy                  copy in progress
//   done                  sticky completion flag, cleared by accepted start
//   flash_addr            read address to controller
//   request_read_addr     one-cycle pulse: addressed read
//   request_read_next     one-cycle pulse: next sequential byte
//   d_ready, d_in         controller byte valid (level) and data
//   ram_addr, ram_data    RAM write address / data
//   ram_we                one-cycle RAM write strobe
//   checksum              8-bit running sum of copied bytes
//                         (only when FLASH_LOADER_CHECKSUM_EN is defined)
// -----------------------------------------------------------------------------
module flash_loader #(
    parameter logic [23:0] FLASH_BASE = 24'h000000,
    parameter int unsigned RAM_BASE   = 0,
    parameter int unsigned LENGTH     = 4096,
    parameter int unsigned RAM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [23:0]           flash_addr,
    output logic                  request_read_addr,
    output logic                  request_read_next,
    input  logic                  d_ready,
    input  logic [7:0]            d_in,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_data,
    output logic                  ram_we
`ifdef FLASH_LOADER_CHECKSUM_EN
    ,
    output logic [7:0]            checksum
`endif
);

    if (longint'(LENGTH) < 1 || longint'(LENGTH) > (longint'(1) << RAM_ADDR_W)) begin : g_bad_length
        $error("flash_loader: LENGTH must be in 1 .. 2^RAM_ADDR_W");
    end

    localparam logic [RAM_ADDR_W-1:0] RAM_BASE_W = RAM_ADDR_W'(RAM_BASE);
    localparam logic [RAM_ADDR_W:0]   LAST_CNT   = (RAM_ADDR_W+1)'(LENGTH - 1);
    localparam logic [RAM_ADDR_W:0]   CNT_ONE    = (RAM_ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ADDR,
        WAIT_BYTE,
        WRITE,
        REQ_NEXT,
        DONE
    } state_t;

    state_t              state;
    logic [RAM_ADDR_W:0] cnt;
    logic                d_ready_q;

`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    assign checksum = csum;
`endif

    // The controller samples the address some cycles after the request,
    // so it is simply held constant.
    assign flash_addr = FLASH_BASE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            request_read_addr <= 1'b0;
            request_read_next <= 1'b0;
            ram_we            <= 1'b0;
            ram_addr          <= '0;
            ram_data          <= '0;
            d_ready_q         <= 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
            csum              <= '0;
`endif
        end else begin
            d_ready_q <= d_ready;
            case (state)
                IDLE: begin
                    if (start) begin
                        state             <= REQ_ADDR;
                        cnt               <= '0;
                        done              <= 1'b0;
                        busy              <= 1'b1;
                        request_read_addr <= 1'b1;
`ifdef FLASH_LOADER_CHECKSUM_EN
                        csum              <= '0;
`endif
                    end
                end
                REQ_ADDR: begin
                    request_read_addr <= 1'b0;
                    state             <= WAIT_BYTE;
                end
                WAIT_BYTE: begin
                    // Only a fresh rising edge is a byte; a level left high
                    // from the previous transfer is ignored.
                    if (d_ready && !d_ready_q) begin
                        ram_data <= d_in;
                        ram_addr <= RAM_BASE_W + cnt[RAM_ADDR_W-1:0];
                        ram_we   <= 1'b1;
                        state    <= WRITE;
                    end
                end
                WRITE: begin
                    ram_we <= 1'b0;
`ifdef FLASH_LOADER_CHECKSUM_EN
                    csum   <= csum + ram_data;
`endif
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end else begin
                        request_read_next <= 1'b1;
                        state             <= REQ_NEXT;
                    end
                end
                REQ_NEXT: begin
                    request_read_next <= 1'b0;
                    cnt               <= cnt + CNT_ONE;
                    state             <= WAIT_BYTE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_loader.sv
// -----------------------------------------------------------------------------
// tb_flash_loader
//
// Three flash_loader instances with different parameter sets share one clock:
//   u0: FLASH_BASE=0x10, RAM_BASE=0,  LENGTH=4, RAM_ADDR_W=14
//   u1: FLASH_BASE=0x10, RAM_BASE=0,  LENGTH=1, RAM_ADDR_W=14
//   u2: FLASH_BASE=0xF0, RAM_BASE=14, LENGTH=4, RAM_ADDR_W=4  (address wrap)
// A randomized flash controller model (byte = address[7:0]+1) serves each one.
// Expected writes, request counts, latencies and checksum come from the copy
// rule itself: k-th write goes to (RAM_BASE+k) mod 2^W with FLASH_BASE+1+k.
// -----------------------------------------------------------------------------
module tb_flash_loader;

    localparam int unsigned       NI = 3;
    localparam logic [23:0]       FB  [NI] = '{24'h000010, 24'h000010, 24'h0000F0};
    localparam int unsigned       RB  [NI] = '{0, 0, 14};
    localparam int unsigned       LEN [NI] = '{4, 1, 4};
    localparam int unsigned       AW  [NI] = '{14, 14, 4};

    logic            clk;
    logic            reset;
    logic [NI-1:0]   start;
    logic [NI-1:0]   busy;
    logic [NI-1:0]   done;
    logic [23:0]     flash_addr [NI];
    logic [NI-1:0]   req_addr;
    logic [NI-1:0]   req_next;
    logic [NI-1:0]   d_ready;
    logic [7:0]      d_in [NI];
    logic [13:0]     ram_addr0;
    logic [13:0]     ram_addr1;
    logic [3:0]      ram_addr2;
    logic [7:0]      ram_data [NI];
    logic [NI-1:0]   ram_we;
`ifdef FLASH_LOADER_CHECKSUM_EN
    logic [7:0]      checksum [NI];
`endif

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // per-instance scoreboard state
    int unsigned wr_k      [NI];
    int unsigned n_addr    [NI];
    int unsigned n_next    [NI];
    int unsigned last_rise [NI];
    logic        prev_dr   [NI];
    logic        prev_done [NI];
    int unsigned ncyc = 0;

    flash_loader #(.FLASH_BASE(24'h000010), .RAM_BASE(0), .LENGTH(4), .RAM_ADDR_W(14)) u0 (
        .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .flash_addr(flash_addr[0]), .request_read_addr(req_addr[0]),
        .request_read_next(req_next[0]), .d_ready(d_ready[0]), .d_in(d_in[0]),
        .ram_addr(ram_addr0), .ram_data(ram_data[0]), .ram_we(ram_we[0])
`ifdef FLASH_LOADER_CHECKSUM_EN
        , .checksum(checksum[0])
`endif
    );

    flash_loader #(.FLASH_BASE(24'h000010), .RAM_BASE(0), .LENGTH(1), .RAM_ADDR_W(14)) u1 (
        .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .flash_addr(flash_addr[1]), .request_read_addr(req_addr[1]),
        .request_read_next(req_next[1]), .d_ready(d_ready[1]), .d_in(d_in[1]),
        .ram_addr(ram_addr1), .ram_data(ram_data[1]), .ram_we(ram_we[1])
`ifdef FLASH_LOADER_CHECKSUM_EN
        , .checksum(checksum[1])
`endif
    );

    flash_loader #(.FLASH_BASE(24'h0000F0), .RAM_BASE(14), .LENGTH(4), .RAM_ADDR_W(4)) u2 (
        .clk(clk), .reset(reset), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .flash_addr(flash_addr[2]), .request_read_addr(req_addr[2]),
        .request_read_next(req_next[2]), .d_ready(d_ready[2]), .d_in(d_in[2]),
        .ram_addr(ram_addr2), .ram_data(ram_data[2]), .ram_we(ram_we[2])
`ifdef FLASH_LOADER_CHECKSUM_EN
        , .checksum(checksum[2])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] get_ram_addr(input int unsigned i);
        case (i)
            0:       return 32'(ram_addr0);
            1:       return 32'(ram_addr1);
            default: return 32'(ram_addr2);
        endcase
    endfunction

    function automatic logic [31:0] exp_addr(input int unsigned i, input int unsigned k);
        return (RB[i] + k) % (32'd1 << AW[i]);
    endfunction

    function automatic logic [31:0] exp_data(input int unsigned i, input int unsigned k);
        return (32'(FB[i]) + 32'd1 + k) % 32'd256;
    endfunction

    function automatic logic [31:0] exp_sum(input int unsigned i);
        int unsigned s = 0;
        for (int unsigned k = 0; k < LEN[i]; k++) s += exp_data(i, k);
        return s % 32'd256;
    endfunction

    // Flash controller model: on a request, d_ready stays at its old level for
    // a random 1..4 cycles, drops, then rises again with the byte after a
    // random delay. The old level lingering after the request exercises the
    // "leftover d_ready is not a byte" rule on every transfer.
    logic [23:0] ptr     [NI];
    int unsigned drop_w  [NI];
    int unsigned rise_w  [NI];
    logic        w_drop  [NI];
    logic        w_rise  [NI];

    initial begin
        d_ready = '0;
        for (int i = 0; i < NI; i++) begin
            d_in[i]   = 8'h00;
            ptr[i]    = 24'h0;
            w_drop[i] = 1'b0;
            w_rise[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (reset) begin
                d_ready[i] <= 1'b0;
                w_drop[i]  <= 1'b0;
                w_rise[i]  <= 1'b0;
            end else if (req_addr[i] || req_next[i]) begin
                ptr[i]    <= req_addr[i] ? flash_addr[i] : ptr[i] + 24'd1;
                drop_w[i] <= $urandom_range(0, 3);
                w_drop[i] <= 1'b1;
                w_rise[i] <= 1'b0;
            end else if (w_drop[i]) begin
                if (drop_w[i] == 0) begin
                    d_ready[i] <= 1'b0;
                    w_drop[i]  <= 1'b0;
                    w_rise[i]  <= 1'b1;
                    rise_w[i]  <= $urandom_range(0, 5);
                end else begin
                    drop_w[i] <= drop_w[i] - 1;
                end
            end else if (w_rise[i]) begin
                if (rise_w[i] == 0) begin
                    d_ready[i] <= 1'b1;
                    d_in[i]    <= ptr[i][7:0] + 8'd1;
                    w_rise[i]  <= 1'b0;
                end else begin
                    rise_w[i] <= rise_w[i] - 1;
                end
            end
        end
    end

    // Monitor: checks every RAM write against the copy rule and its latency
    // from the d_ready edge, counts requests, and times done.
    initial begin
        for (int i = 0; i < NI; i++) begin
            wr_k[i] = 0; n_addr[i] = 0; n_next[i] = 0; last_rise[i] = 0;
            prev_dr[i] = 1'b0; prev_done[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        ncyc++;
        for (int unsigned i = 0; i < NI; i++) begin
            if (!reset) begin
                if (d_ready[i] && !prev_dr[i]) last_rise[i] = ncyc;
                if (req_addr[i] || req_next[i]) begin
                    check($sformatf("u%0d req_overlap", i), 32'(req_addr[i] & req_next[i]), 32'd0);
                    if (req_addr[i]) n_addr[i]++;
                    if (req_next[i]) n_next[i]++;
                end
                if (ram_we[i]) begin
                    check($sformatf("u%0d wr%0d_addr", i, wr_k[i]), get_ram_addr(i), exp_addr(i, wr_k[i]));
                    check($sformatf("u%0d wr%0d_data", i, wr_k[i]), 32'(ram_data[i]), exp_data(i, wr_k[i]));
                    check($sformatf("u%0d wr_latency", i), ncyc - last_rise[i], 32'd1);
                    wr_k[i]++;
                end
                if (done[i] && !prev_done[i])
                    check($sformatf("u%0d done_latency", i), ncyc - last_rise[i], 32'd3);
            end
            prev_dr[i]   = d_ready[i];
            prev_done[i] = done[i];
        end
    end

    task automatic check_reset_vals(input int unsigned i);
        check($sformatf("u%0d rst_busy", i),     32'(busy[i]),     32'd0);
        check($sformatf("u%0d rst_done", i),     32'(done[i]),     32'd0);
        check($sformatf("u%0d rst_req_addr", i), 32'(req_addr[i]), 32'd0);
        check($sformatf("u%0d rst_req_next", i), 32'(req_next[i]), 32'd0);
        check($sformatf("u%0d rst_ram_we", i),   32'(ram_we[i]),   32'd0);
        check($sformatf("u%0d rst_ram_addr", i), get_ram_addr(i),  32'd0);
        check($sformatf("u%0d rst_ram_data", i), 32'(ram_data[i]), 32'd0);
`ifdef FLASH_LOADER_CHECKSUM_EN
        check($sformatf("u%0d rst_checksum", i), 32'(checksum[i]), 32'd0);
`endif
    endtask

    task automatic launch(input logic [NI-1:0] mask);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (mask[i]) begin
                wr_k[i] = 0; n_addr[i] = 0; n_next[i] = 0;
            end
        end
        start = mask;
        @(negedge clk);
        start = '0;
        for (int unsigned i = 0; i < NI; i++) begin
            if (mask[i]) begin
                check($sformatf("u%0d start_busy", i),     32'(busy[i]),     32'd1);
                check($sformatf("u%0d start_done_clr", i), 32'(done[i]),     32'd0);
                check($sformatf("u%0d start_req_addr", i), 32'(req_addr[i]), 32'd1);
            end
        end
    endtask

    task automatic run_copy(input logic [NI-1:0] mask);
        int unsigned cyc = 0;
        logic        all_done = 1'b0;
        launch(mask);
        while (!all_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            start = '0;
            // stray start pulses while busy must be ignored
            for (int i = 0; i < NI; i++)
                if (mask[i] && busy[i] && $urandom_range(0, 5) == 0) start[i] = 1'b1;
            all_done = 1'b1;
            for (int i = 0; i < NI; i++)
                if (mask[i] && !done[i]) all_done = 1'b0;
        end
        start = '0;
        check("copy_timeout", 32'(all_done), 32'd1);
        for (int unsigned i = 0; i < NI; i++) begin
            if (mask[i]) begin
                check($sformatf("u%0d n_writes", i),  wr_k[i],   LEN[i]);
                check($sformatf("u%0d n_req_addr", i), n_addr[i], 32'd1);
                check($sformatf("u%0d n_req_next", i), n_next[i], LEN[i] - 1);
                check($sformatf("u%0d end_busy", i),  32'(busy[i]), 32'd0);
                check($sformatf("u%0d end_done", i),  32'(done[i]), 32'd1);
`ifdef FLASH_LOADER_CHECKSUM_EN
                check($sformatf("u%0d checksum", i),  32'(checksum[i]), exp_sum(i));
`endif
            end
        end
        repeat (3) @(negedge clk);
        for (int unsigned i = 0; i < NI; i++)
            if (mask[i]) check($sformatf("u%0d done_sticky", i), 32'(done[i]), 32'd1);
    endtask

    initial begin
        int unsigned cyc;
        int unsigned snap_w, snap_a, snap_n;
        start = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int unsigned i = 0; i < NI; i++) check_reset_vals(i);
        reset = 1'b0;

        for (int r = 0; r < 6; r++) run_copy('1);

        // reset after the second write of a copy
        launch(3'b001);
        cyc = 0;
        while (wr_k[0] < 2 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("midcopy_timeout", 32'(wr_k[0] >= 2), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        for (int unsigned i = 0; i < NI; i++) check_reset_vals(i);
        reset  = 1'b0;
        snap_w = wr_k[0];
        snap_a = n_addr[0];
        snap_n = n_next[0];
        repeat (30) @(negedge clk);
        check("post_rst_writes",   wr_k[0],   snap_w);
        check("post_rst_req_addr", n_addr[0], snap_a);
        check("post_rst_req_next", n_next[0], snap_n);
        check("post_rst_busy",     32'(busy[0]), 32'd0);
        check("post_rst_done",     32'(done[0]), 32'd0);

        // a fresh start after reset copies normally again
        run_copy('1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flash_loader.md
# flash_loader

Boot-time copy engine sitting directly downstream of the flash controller. On a `start` pulse it issues one addressed read, then streams `LENGTH` sequential bytes out of SPI flash and writes each into the VIC-side RAM (character ROM / initial screen image). It signals completion with a sticky `done`, so the rest of the design can be held off until memory is populated.

## Interface
Parameters:
- `FLASH_BASE`, 24'h000000: first flash byte address.
- `RAM_BASE`, 0: first RAM write address.
- `LENGTH`, 4096: bytes to copy; must be ≥1 and ≤2^`RAM_ADDR_W` (elaboration error otherwise).
- `RAM_ADDR_W`, 14: RAM address width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is synchronous and active-high.
- `start`  in  1  one-cycle pulse; begins a copy when idle.
- `busy`  out  1  copy in progress.
- `done`  out  1  sticky: copy completed; cleared by next accepted `start` or by reset.
- `flash_addr`  out  24  read address to controller.
- `request_read_addr`  out  1  one-cycle pulse: addressed read.
- `request_read_next`  out  1  one-cycle pulse: next sequential byte.
- `d_ready`  in  1  controller byte valid (level, held until next request).
- `d_in`  in  8  controller byte.
- `ram_addr`  out  `RAM_ADDR_W`  write address.
- `ram_data`  out  8  write data.
- `ram_we`  out  1  one-cycle write strobe.
- `checksum`  out  8  only with `FLASH_LOADER_CHECKSUM_EN`.

## Operation
- States: IDLE, REQ_ADDR, WAIT_BYTE, WRITE, REQ_NEXT, DONE.
- IDLE: `start`=1 → REQ_ADDR; byte counter `cnt`←0; `done`←0; `busy`←1.
- REQ_ADDR: `request_read_addr`=1 for exactly this cycle → WAIT_BYTE.
- WAIT_BYTE: wait for rising edge of `d_ready` (`d_ready` & ~`d_ready_q`, `d_ready_q` registered every cycle). A level-high `d_ready` left over from a previous transfer is never a byte. On edge: latch `d_in` → `ram_data`, `ram_addr` ← (`RAM_BASE`+`cnt`) mod 2^`RAM_ADDR_W` → WRITE.
- WRITE: `ram_we`=1 for this cycle only. If `cnt`==`LENGTH`-1 → DONE, else → REQ_NEXT.
- REQ_NEXT: `request_read_next`=1 for this cycle; `cnt`←`cnt`+1 → WAIT_BYTE.
- DONE: `busy`←0, `done`←1 → IDLE.
- `flash_addr` is driven constantly to `FLASH_BASE` (controller samples it several cycles after the request).
- `start` while busy: ignored, no effect on counter or outputs.
- `cnt` is `RAM_ADDR_W`+1 bits wide; RAM address wraps modulo 2^`RAM_ADDR_W`.

## Timing
- Reset values: `busy`=0, `done`=0, `request_read_addr`=0, `request_read_next`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0, `checksum`=0; state IDLE; `d_ready_q`=0.
- Reset mid-copy: next cycle in IDLE, all strobes low, no further requests; partial RAM contents are left in place.
- `start` sampled at edge N → `busy`=1 after N, `request_read_addr` high in cycle N+1.
- `d_ready` edge seen at edge M → `ram_we` high in cycle M+1 with stable `ram_addr`/`ram_data`; `request_read_next` in cycle M+2.
- Loader overhead: 3 cycles per byte plus controller latency; `done` rises 2 cycles after the final edge of `d_ready`.
- Request pulses never overlap; exactly one request is outstanding at a time.

## Configuration
- `FLASH_LOADER_CHECKSUM_EN` defined: `checksum` port exists; reset to 0 on accepted `start`, += `d_in` (mod 256) on each WRITE; final value stable from `done` until next `start`.
- Undefined: no `checksum` port, no adder logic; behaviour otherwise identical.

## Test plan
- `FLASH_BASE`=0x000010, `LENGTH`=4, `RAM_BASE`=0, simulation flash model (byte = addr[7:0]+1, incrementing) → RAM writes 0x11,0x12,0x13,0x14 at 0..3; exactly 1 `request_read_addr`, 3 `request_read_next`; `done`=1; checksum 0x4A when enabled.
- `LENGTH`=1 → single write of 0x11, zero `request_read_next`, `done` 2 cycles after `d_ready` edge.
- `RAM_ADDR_W`=4, `RAM_BASE`=14, `LENGTH`=4 → writes at 14,15,0,1.
- `start` pulsed again mid-copy → ignored, write count unchanged at `LENGTH`; second `start` after `done` → `done` clears, copy repeats identically.
- `reset` asserted after 2nd write → all outputs at reset values next cycle, no further `ram_we` or requests until new `start`.
- `d_ready` held high from a previous transfer at `start` → no write until `d_ready` falls and rises again.
